// File: rtl/signal_phase_arbiter_if.sv
// Bus between the phase arbiter and the approach sensors / lamp drivers.
// Signalling contract: req is a level per approach, sampled on every rising
// clock edge and never latched; grant_valid is high exactly while grant_id
// names the approach holding GREEN or YELLOW; phase_start pulses for one cycle
// with the first green cycle of each grant. There is no back-pressure.
interface signal_phase_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [2*N-1:0] light;
    logic [IW-1:0]  grant_id;
    logic           grant_valid;
    logic           phase_start;
    logic [1:0]     fsm_state;

    // Sensor / lamp-driver side
    modport master (
        output req,
        input  light, grant_id, grant_valid, phase_start, fsm_state
    );

    // Arbiter side
    modport slave (
        input  req,
        output light, grant_id, grant_valid, phase_start, fsm_state
    );
endinterface

// File: rtl/signal_phase_arbiter.sv
// Round-robin phase scheduler for an N-approach intersection: one approach at
// a time goes green -> yellow -> all-red, with min/max green and fixed
// clearance intervals. fsm_state on the bus exposes the controller state.
module signal_phase_arbiter #(
    parameter int N         = 4,
    parameter int CW        = 16,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic                  clock,
    input  logic                  clear,
    signal_phase_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;
    localparam logic [1:0] S_ALLRED = 2'd3;

    localparam logic [CW-1:0] G_MIN_L  = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] G_MAX_L  = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] AR_LAST  = CW'(ALLRED_T - 1);

    logic [1:0]     state;
    logic [CW-1:0]  timer;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  grant_id;
    logic [2*N-1:0] light;
    logic           grant_valid;
    logic           phase_start;

    logic [IW-1:0]  win;
    logic           any_req;
    logic [N-1:0]   masked_req;
    logic           other;
    logic           own;
    logic           green_exit;

    // First requesting approach at or above ptr, wrapping from N-1 to 0.
    always_comb begin
        logic [IW-1:0] cand;
        logic          found;
        win   = ptr;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && bus.req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Competing demand and the green exit decision for the current holder.
    always_comb begin
        masked_req           = bus.req;
        masked_req[grant_id] = 1'b0;
        any_req    = |bus.req;
        other      = |masked_req;
        own        = bus.req[grant_id];
        green_exit = (timer >= G_MIN_L) && other && (!own || (timer == G_MAX_L));
    end

    // Phase sequencer; every output is a register updated here.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= S_IDLE;
            timer       <= '0;
            ptr         <= '0;
            grant_id    <= '0;
            light       <= '0;
            grant_valid <= 1'b0;
            phase_start <= 1'b0;
        end else begin
            phase_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        state              <= S_GREEN;
                        grant_id           <= win;
                        timer              <= '0;
                        phase_start        <= 1'b1;
                        grant_valid        <= 1'b1;
                        light              <= '0;
                        light[{win, 1'b0} +: 2] <= 2'b10;
                    end
                end
                S_GREEN: begin
                    if (green_exit) begin
                        state <= S_YELLOW;
                        timer <= '0;
                        light <= '0;
                        light[{grant_id, 1'b0} +: 2] <= 2'b01;
                    end else if (timer != G_MAX_L) begin
                        timer <= timer + 1'b1;
                    end
                end
                S_YELLOW: begin
                    if (timer == Y_LAST) begin
                        state       <= S_ALLRED;
                        timer       <= '0;
                        light       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    // All-red clearance; ptr already points past the last holder.
                    if (timer == AR_LAST) begin
                        timer <= '0;
                        if (any_req) begin
                            state              <= S_GREEN;
                            grant_id           <= win;
                            phase_start        <= 1'b1;
                            grant_valid        <= 1'b1;
                            light              <= '0;
                            light[{win, 1'b0} +: 2] <= 2'b10;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.light       = light;
    assign bus.grant_id    = grant_id;
    assign bus.grant_valid = grant_valid;
    assign bus.phase_start = phase_start;
    assign bus.fsm_state   = state;
endmodule
